fifo_pic_bridge: RTL

- Downstream of the FIFO flag controller.
- When `read` is high and the FIFO is not empty, pops 16-bit samples from the external Doppler sample FIFO.
- Hands each sample to the PIC as two bytes, high byte first, over a 4-phase strobe/ack handshake.
- Limits burst length, detects a PIC ack timeout, and reports busy, error and transferred-word count.

---
 rtl/fifo_pic_bridge_pkg.sv | 24 ++
 rtl/fifo_pic_bridge_sync_2ff.sv | 23 ++
 rtl/fifo_pic_bridge.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fifo_pic_bridge_pkg.sv
// Shared definitions for the FIFO-to-PIC bridge: FSM state encodings, bus
// widths, the default handshake timeout and a state-class helper.
package fifo_pic_bridge_pkg;

  localparam int unsigned STATE_W     = 3;
  localparam int unsigned FIFO_W      = 16;
  localparam int unsigned PIC_W       = 8;
  localparam int unsigned TIMEOUT_DEF = 1023;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_RDEN    = 3'd1;
  localparam logic [STATE_W-1:0] ST_LAT     = 3'd2;
  localparam logic [STATE_W-1:0] ST_HI_STRB = 3'd3;
  localparam logic [STATE_W-1:0] ST_HI_REL  = 3'd4;
  localparam logic [STATE_W-1:0] ST_LO_STRB = 3'd5;
  localparam logic [STATE_W-1:0] ST_LO_REL  = 3'd6;

  // True for the four states that wait on the PIC and are timeout-guarded.
  function automatic logic is_handshake(input logic [STATE_W-1:0] st);
    return (st == ST_HI_STRB) || (st == ST_HI_REL) ||
           (st == ST_LO_STRB) || (st == ST_LO_REL);
  endfunction

endpackage

// File: rtl/fifo_pic_bridge_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: CLK (clock), Reset (async, active high), d (async input),
//        q (synchronised output, 2-cycle latency).
module fifo_pic_bridge_sync_2ff (
  input  logic CLK,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_pic_bridge.sv
// Drains 16-bit samples from the Doppler sample FIFO and hands each one to the
// PIC as two bytes (high first) over a 4-phase strobe/ack handshake, with burst
// limiting, ack timeout detection and a delivered-word counter.
// Ports: CLK, Reset (async, active high); read/EF request and empty flag;
//        fifo_data/fifo_ren FIFO read side; pic_data/pic_strb/pic_ack PIC side;
//        clr_err clears err in IDLE; busy, err, word_cnt status.
module fifo_pic_bridge
  import fifo_pic_bridge_pkg::*;
#(
  parameter int unsigned DW        = FIFO_W,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned BURST_MAX = 256
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             read,
  input  logic             EF,
  input  logic [DW-1:0]    fifo_data,
  output logic             fifo_ren,
  output logic [PIC_W-1:0] pic_data,
  output logic             pic_strb,
  input  logic             pic_ack,
  input  logic             clr_err,
  output logic             busy,
  output logic             err,
  output logic [15:0]      word_cnt
);

  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned BST_W = $clog2(BURST_MAX + 1);

  logic [STATE_W-1:0] state, state_nxt;
  logic [LAT_W-1:0]   lat_cnt, lat_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
  logic [BST_W-1:0]   burst_cnt, burst_nxt;
  logic [DW-1:0]      word_reg, word_nxt;
  logic [PIC_W-1:0]   pdata_nxt;
  logic [15:0]        wcnt_nxt;
  logic               err_nxt;
  logic               ack_s;

  fifo_pic_bridge_sync_2ff u_ack_sync (
    .CLK   (CLK),
    .Reset (Reset),
    .d     (pic_ack),
    .q     (ack_s)
  );

  // Next-state, counters and next output values.
  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    tmo_nxt   = tmo_cnt;
    burst_nxt = burst_cnt;
    word_nxt  = word_reg;
    wcnt_nxt  = word_cnt;
    err_nxt   = err;
    pdata_nxt = pic_data;

    case (state)
      ST_IDLE: begin
        if (clr_err) err_nxt = 1'b0;
        if (read && !EF && !err) state_nxt = ST_RDEN;
      end
      ST_RDEN: begin
        lat_nxt   = '0;
        state_nxt = ST_LAT;
      end
      ST_LAT: begin
        if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
          word_nxt  = fifo_data;
          state_nxt = ST_HI_STRB;
        end else begin
          lat_nxt = lat_cnt + LAT_W'(1);
        end
      end
      ST_HI_STRB: if (ack_s)  state_nxt = ST_HI_REL;
      ST_HI_REL:  if (!ack_s) state_nxt = ST_LO_STRB;
      ST_LO_STRB: if (ack_s)  state_nxt = ST_LO_REL;
      ST_LO_REL: begin
        if (!ack_s) begin
          wcnt_nxt = word_cnt + 16'd1;
          if (read && !EF && (burst_cnt < BST_W'(BURST_MAX - 1))) begin
            burst_nxt = burst_cnt + BST_W'(1);
            state_nxt = ST_RDEN;
          end else begin
            burst_nxt = '0;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A stalled handshake aborts on its TIMEOUT-th cycle; the partial word is dropped.
    if (is_handshake(state) && (state_nxt == state)) begin
      if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
        state_nxt = ST_IDLE;
        err_nxt   = 1'b1;
        burst_nxt = '0;
      end else begin
        tmo_nxt = tmo_cnt + TMO_W'(1);
      end
    end
    if (state_nxt != state) tmo_nxt = '0;

    // pic_data is only updated on entry to a strobe state, otherwise held.
    if (state_nxt == ST_HI_STRB)      pdata_nxt = word_nxt[DW-1 -: PIC_W];
    else if (state_nxt == ST_LO_STRB) pdata_nxt = word_nxt[PIC_W-1:0];
  end

  // State register and registered outputs decoded from the next state.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      lat_cnt   <= '0;
      tmo_cnt   <= '0;
      burst_cnt <= '0;
      word_reg  <= '0;
      word_cnt  <= '0;
      err       <= 1'b0;
      pic_data  <= '0;
      pic_strb  <= 1'b0;
      fifo_ren  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      lat_cnt   <= lat_nxt;
      tmo_cnt   <= tmo_nxt;
      burst_cnt <= burst_nxt;
      word_reg  <= word_nxt;
      word_cnt  <= wcnt_nxt;
      err       <= err_nxt;
      pic_data  <= pdata_nxt;
      pic_strb  <= (state_nxt == ST_HI_STRB) || (state_nxt == ST_LO_STRB);
      fifo_ren  <= (state_nxt == ST_RDEN);
      busy      <= (state_nxt != ST_IDLE);
    end
  end

endmodule
